// File: rtl/change_detect_reg_bank.sv
// Per-channel glitch-filtered register bank with change pulses,
// sticky change flags and a saturating change-event counter.
module change_detect_reg_bank #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 1,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [WIDTH-1:0]     d,
  input  logic [1:0]           mode,
  input  logic                 clr_flags,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     chg_pulse,
  output logic [WIDTH-1:0]     chg_sticky,
  output logic                 chg_any,
  output logic [CNT_WIDTH-1:0] chg_count
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         q_q, q_d;
  logic [WIDTH-1:0]         pulse_q, pulse_d;
  logic [WIDTH-1:0]         sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0]     count_q, count_d;

  logic [WIDTH-1:0] diff, commit, qual;
  logic             rise_ok, fall_ok, ev;

  always_comb begin
    rise_ok = 1'b0;
    fall_ok = 1'b0;
    unique case (mode)
      2'b00: begin
        rise_ok = 1'b1;
        fall_ok = 1'b1;
      end
      2'b01: rise_ok = 1'b1;
      2'b10: fall_ok = 1'b1;
      default: ;
    endcase
  end

  // diff=1 implies the new value is simply ~q, so no candidate storage
  always_comb begin
    diff   = d ^ q_q;
    commit = '0;
    qual   = '0;
    cnt_d  = cnt_q;
    q_d    = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (en) begin
        if (!diff[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == LAST) begin
          commit[i] = 1'b1;
          q_d[i]    = d[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
      qual[i] = commit[i] & (d[i] ? rise_ok : fall_ok);
    end
  end

  // clear loses to a coincident event for both flags and count
  always_comb begin
    ev       = |qual;
    pulse_d  = qual;
    sticky_d = (clr_flags ? '0 : sticky_q) | qual;
    count_d  = count_q;
    if (clr_flags) begin
      count_d = ev ? CNT_WIDTH'(1) : '0;
    end else if (ev && count_q != CNT_MAX) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      q_q      <= '0;
      pulse_q  <= '0;
      sticky_q <= '0;
      count_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign q          = q_q;
  assign chg_pulse  = pulse_q;
  assign chg_sticky = sticky_q;
  assign chg_any    = |sticky_q;
  assign chg_count  = count_q;

endmodule

// File: tb/tb_change_detect_reg_bank.sv
// Directed bench: four instances with different filter depths
// share one stimulus bus; each scenario checks its own instance.
module tb_change_detect_reg_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] d;
  logic [1:0] mode;
  logic       clr;

  logic [7:0] q_a, p_a, s_a;
  logic       any_a;
  logic [1:0] c_a;
  logic [7:0] q_b, p_b, s_b, c_b;
  logic       any_b;
  logic [7:0] q_c, p_c, s_c, c_c;
  logic       any_c;
  logic [7:0] q_d, p_d, s_d, c_d;
  logic       any_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  change_detect_reg_bank #(.WIDTH(8), .STABLE_CYCLES(1), .CNT_WIDTH(2)) u_a (
    .clk(clk), .reset(reset), .en(en), .d(d), .mode(mode),
    .clr_flags(clr), .q(q_a), .chg_pulse(p_a), .chg_sticky(s_a),
    .chg_any(any_a), .chg_count(c_a));

  change_detect_reg_bank #(.WIDTH(8), .STABLE_CYCLES(3), .CNT_WIDTH(8)) u_b (
    .clk(clk), .reset(reset), .en(en), .d(d), .mode(mode),
    .clr_flags(clr), .q(q_b), .chg_pulse(p_b), .chg_sticky(s_b),
    .chg_any(any_b), .chg_count(c_b));

  change_detect_reg_bank #(.WIDTH(8), .STABLE_CYCLES(2), .CNT_WIDTH(8)) u_c (
    .clk(clk), .reset(reset), .en(en), .d(d), .mode(mode),
    .clr_flags(clr), .q(q_c), .chg_pulse(p_c), .chg_sticky(s_c),
    .chg_any(any_c), .chg_count(c_c));

  change_detect_reg_bank #(.WIDTH(8), .STABLE_CYCLES(4), .CNT_WIDTH(8)) u_d (
    .clk(clk), .reset(reset), .en(en), .d(d), .mode(mode),
    .clr_flags(clr), .q(q_d), .chg_pulse(p_d), .chg_sticky(s_d),
    .chg_any(any_d), .chg_count(c_d));

  typedef struct {
    logic       en;
    logic [7:0] d;
    logic [1:0] mode;
    logic       clr;
    logic [7:0] q;
    logic [7:0] pulse;
    logic [7:0] sticky;
    logic [1:0] cnt;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    d     = '0;
    mode  = 2'b00;
    clr   = 1'b0;
    #3;
    reset = 1'b0;
    step();
  endtask

  int npulse;

  initial begin
    reset = 1'b1;
    en = 1'b0;
    d = '0;
    mode = 2'b00;
    clr = 1'b0;

    // en d mode clr | q pulse sticky cnt
    tbl[0]  = '{1'b1, 8'hA5, 2'b00, 1'b0, 8'hA5, 8'hA5, 8'hA5, 2'd1};
    tbl[1]  = '{1'b1, 8'hA5, 2'b00, 1'b0, 8'hA5, 8'h00, 8'hA5, 2'd1};
    tbl[2]  = '{1'b1, 8'hA5, 2'b00, 1'b1, 8'hA5, 8'h00, 8'h00, 2'd0};
    tbl[3]  = '{1'b1, 8'hAD, 2'b01, 1'b0, 8'hAD, 8'h08, 8'h08, 2'd1};
    tbl[4]  = '{1'b1, 8'hA5, 2'b01, 1'b0, 8'hA5, 8'h00, 8'h08, 2'd1};
    tbl[5]  = '{1'b1, 8'hAD, 2'b11, 1'b0, 8'hAD, 8'h00, 8'h08, 2'd1};
    tbl[6]  = '{1'b1, 8'hA5, 2'b11, 1'b0, 8'hA5, 8'h00, 8'h08, 2'd1};
    tbl[7]  = '{1'b1, 8'hAD, 2'b10, 1'b0, 8'hAD, 8'h00, 8'h08, 2'd1};
    tbl[8]  = '{1'b1, 8'hA5, 2'b10, 1'b0, 8'hA5, 8'h08, 8'h08, 2'd2};
    tbl[9]  = '{1'b0, 8'h00, 2'b00, 1'b0, 8'hA5, 8'h00, 8'h08, 2'd2};
    tbl[10] = '{1'b0, 8'h00, 2'b00, 1'b1, 8'hA5, 8'h00, 8'h00, 2'd0};
    tbl[11] = '{1'b1, 8'h00, 2'b00, 1'b0, 8'h00, 8'hA5, 8'hA5, 2'd1};
    tbl[12] = '{1'b1, 8'h01, 2'b00, 1'b0, 8'h01, 8'h01, 8'hA5, 2'd2};
    tbl[13] = '{1'b1, 8'h00, 2'b00, 1'b0, 8'h00, 8'h01, 8'hA5, 2'd3};
    tbl[14] = '{1'b1, 8'h01, 2'b00, 1'b0, 8'h01, 8'h01, 8'hA5, 2'd3};
    tbl[15] = '{1'b1, 8'h00, 2'b00, 1'b0, 8'h00, 8'h01, 8'hA5, 2'd3};
    tbl[16] = '{1'b1, 8'h04, 2'b00, 1'b1, 8'h04, 8'h04, 8'h04, 2'd1};
    tbl[17] = '{1'b1, 8'h04, 2'b00, 1'b0, 8'h04, 8'h00, 8'h04, 2'd1};

    #2;
    chk("rst_q_a", 32'(q_a), 32'h0);
    chk("rst_pulse_a", 32'(p_a), 32'h0);
    chk("rst_sticky_a", 32'(s_a), 32'h0);
    chk("rst_any_a", 32'(any_a), 32'h0);
    chk("rst_cnt_a", 32'(c_a), 32'h0);
    reset = 1'b0;
    step();

    // follow, mode filtering, en hold, saturation, clear/set collision
    for (int i = 0; i < 18; i++) begin
      en   = tbl[i].en;
      d    = tbl[i].d;
      mode = tbl[i].mode;
      clr  = tbl[i].clr;
      step();
      chk($sformatf("v%0d_q", i), 32'(q_a), 32'(tbl[i].q));
      chk($sformatf("v%0d_pulse", i), 32'(p_a), 32'(tbl[i].pulse));
      chk($sformatf("v%0d_sticky", i), 32'(s_a), 32'(tbl[i].sticky));
      chk($sformatf("v%0d_any", i), 32'(any_a), 32'(|tbl[i].sticky));
      chk($sformatf("v%0d_cnt", i), 32'(c_a), 32'(tbl[i].cnt));
    end

    // glitch rejection, depth 3
    do_reset();
    en = 1'b1;
    npulse = 0;
    for (int i = 0; i < 7; i++) begin
      d = (i == 2) ? 8'h00 : 8'h01;
      step();
      if (p_b[0]) npulse++;
      chk($sformatf("glitch_q_%0d", i), 32'(q_b[0]), (i == 5 || i == 6) ? 32'h1 : 32'h0);
    end
    chk("glitch_pulses", 32'(npulse), 32'd1);
    chk("glitch_cnt", 32'(c_b), 32'd1);

    // enable hold, depth 2
    do_reset();
    en = 1'b1;
    d  = 8'h02;
    step();
    chk("hold_q_pre", 32'(q_c), 32'h0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("hold_q_%0d", i), 32'(q_c), 32'h0);
      chk($sformatf("hold_pulse_%0d", i), 32'(p_c), 32'h0);
    end
    en = 1'b1;
    step();
    chk("hold_q_post", 32'(q_c), 32'h02);
    chk("hold_pulse_post", 32'(p_c), 32'h02);

    // async reset mid-qualification, depth 4
    do_reset();
    en = 1'b1;
    d  = 8'h01;
    repeat (4) step();
    chk("ar_q_commit", 32'(q_d), 32'h01);
    chk("ar_cnt_commit", 32'(c_d), 32'h1);
    d = 8'h00;
    repeat (2) step();
    #2;
    reset = 1'b1;
    #1;
    chk("ar_q_imm", 32'(q_d), 32'h0);
    chk("ar_cnt_imm", 32'(c_d), 32'h0);
    chk("ar_sticky_imm", 32'(s_d), 32'h0);
    chk("ar_any_imm", 32'(any_d), 32'h0);
    #1;
    reset = 1'b0;
    d = 8'h01;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("ar_q_%0d", i), 32'(q_d[0]), (i == 3) ? 32'h1 : 32'h0);
    end
    chk("ar_pulse_final", 32'(p_d), 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
